flash_arbiter: RTL and testbench

Two-port arbiter that shares the single flash read port between the core's instruction-fetch path and its data-load path. It serialises requests, drives the flash read strobe and address, tracks the `flash_busy` handshake, and returns read data with a one-cycle acknowledge to the winning requester. It sits between the control unit / load-store path and the flash model, replacing the direct `ld_flash` connection.

---
 rtl/flash_arbiter_pkg.sv | 21 ++
 rtl/flash_arbiter_if.sv | 32 +++
 rtl/flash_arbiter_rr2.sv | 23 ++
 rtl/flash_arbiter.sv | 167 ++++++++++++++++
 tb/tb_flash_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_arbiter_pkg.sv
// Shared types for the flash read-port arbiter: FSM states, grant encoding, timeout counter width.
package flash_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } fa_state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int FA_CNT_W = 16;

  function automatic logic other_port(input logic g);
    return (g == GNT_I) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/flash_arbiter_if.sv
// Requester (fetch/data) and flash-side signals of the arbiter; slave = arbiter, master = environment.
interface flash_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              fl_rd;
  logic [ADDR_W-1:0] fl_addr;
  logic              flash_busy;
  logic [DATA_W-1:0] fl_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, flash_busy, fl_rdata,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err, fl_rd, fl_addr
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, flash_busy, fl_rdata,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err, fl_rd, fl_addr
  );
endinterface

// File: rtl/flash_arbiter_rr2.sv
// Combinational 2-way round-robin pick; on contention the port not granted last wins.
module arb_rr2
  import flash_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant,
  output logic any_req
);

  always_comb begin
    any_req = if_req | d_req;
    if (if_req && d_req) begin
      grant = other_port(last_grant);
    end else if (d_req) begin
      grant = GNT_D;
    end else begin
      grant = GNT_I;
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// Shares one flash read port between fetch and data paths; min 4-cycle latency, one read per >=5 cycles.
// Requesters hold req until their ack pulse; FLASH_ARB_TIMEOUT_EN adds an abort-on-timeout counter.
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef FLASH_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic           clk,
  input  logic           rst,
  flash_arbiter_if.slave bus
);

  fa_state_t         state;
  fa_state_t         state_nx;
  logic              last_grant;
  logic              grant_q;
  logic              arb_grant;
  logic              arb_any;

  logic              fl_rd_q;
  logic [ADDR_W-1:0] fl_addr_q;
  logic              if_ack_q;
  logic              d_ack_q;
  logic              if_err_q;
  logic              d_err_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              timeout_hit;
  logic              rsp_load;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;

  arb_rr2 u_arb (
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam logic [FA_CNT_W-1:0] TMO_LIM = FA_CNT_W'(TIMEOUT);

  logic [FA_CNT_W-1:0] tmo_cnt;
  logic                waiting;

  assign waiting = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      tmo_cnt <= '0;
    end else if (waiting) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout_hit = waiting && (tmo_cnt == TMO_LIM);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rsp_load = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = bus.fl_rdata;
    unique case (state)
      ST_IDLE: begin
        if (arb_any) begin
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nx = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (timeout_hit) begin
          state_nx = ST_RESP;
          rsp_load = 1'b1;
          rsp_err  = 1'b1;
          rsp_data = '0;
        end else if (bus.flash_busy) begin
          state_nx = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // Real completion wins over a timeout landing on the same cycle.
        if (!bus.flash_busy) begin
          state_nx = ST_RESP;
          rsp_load = 1'b1;
        end else if (timeout_hit) begin
          state_nx = ST_RESP;
          rsp_load = 1'b1;
          rsp_err  = 1'b1;
          rsp_data = '0;
        end
      end
      ST_RESP: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= GNT_D;
      grant_q    <= GNT_I;
      fl_rd_q    <= 1'b0;
      fl_addr_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      fl_rd_q  <= (state_nx == ST_ISSUE);
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      // Address is frozen at grant; later changes on the requester side are ignored.
      if (state == ST_IDLE && arb_any) begin
        grant_q    <= arb_grant;
        last_grant <= arb_grant;
        fl_addr_q  <= (arb_grant == GNT_D) ? bus.d_addr : bus.if_addr;
      end
      if (rsp_load) begin
        if (grant_q == GNT_D) begin
          d_ack_q   <= 1'b1;
          d_rdata_q <= rsp_data;
          d_err_q   <= rsp_err;
        end else begin
          if_ack_q   <= 1'b1;
          if_rdata_q <= rsp_data;
          if_err_q   <= rsp_err;
        end
      end
    end
  end

  assign bus.fl_rd    = fl_rd_q;
  assign bus.fl_addr  = fl_addr_q;
  assign bus.if_ack   = if_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.if_err   = if_err_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_err    = d_err_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Scoreboard bench for flash_arbiter with a behavioural flash model driven on the falling edge.
module tb_flash_arbiter;
  import flash_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  flash_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  flash_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW)
`ifdef FLASH_ARB_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          port;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_len = 1;
  bit   busy_stuck = 0;
  int   rd_cyc = 0;
  int   exp_d_gap = 0;
  int   last_d_cyc = -1;
  logic prev_ia = 1'b0;
  logic prev_da = 1'b0;
  bit   pend = 0;
  int   left = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_fn(input logic [AW-1:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  task automatic push_exp(input logic port, input logic [AW-1:0] addr, input logic [DW-1:0] rdata,
                          input logic err, input int lat);
    exp_t e;
    e.port = port; e.addr = addr; e.rdata = rdata; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Flash model: busy rises the cycle after fl_rd, holds busy_len cycles, data valid as it falls.
  always @(negedge clk) begin
    if (!rst) begin
      bus.flash_busy = 1'b0;
      bus.fl_rdata   = '0;
      pend = 0;
      left = 0;
    end else if (bus.fl_rd) begin
      pend = 1;
    end else if (pend) begin
      pend = 0;
      bus.flash_busy = 1'b1;
      left = busy_len;
    end else if (bus.flash_busy && !busy_stuck) begin
      left--;
      if (left <= 0) begin
        bus.flash_busy = 1'b0;
        bus.fl_rdata   = data_fn(bus.fl_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (bus.fl_rd) begin
        check_eq("fl_rd_expected", sb.size() > 0, 1);
        if (sb.size() > 0) check_eq("fl_addr", bus.fl_addr, sb[0].addr);
        rd_cyc = cyc;
      end
      if (bus.if_ack || bus.d_ack) begin
        check_eq("ack_onehot", bus.if_ack & bus.d_ack, 0);
        check_eq("ack_pulse", (bus.if_ack & prev_ia) | (bus.d_ack & prev_da), 0);
        check_eq("ack_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check_eq("ack_port", bus.d_ack, mon_e.port);
          check_eq("ack_lat", cyc - rd_cyc, mon_e.lat);
          check_eq("ack_rdata", mon_e.port ? bus.d_rdata : bus.if_rdata, mon_e.rdata);
          check_eq("ack_err", mon_e.port ? bus.d_err : bus.if_err, mon_e.err);
          check_eq("fl_addr_hold", bus.fl_addr, mon_e.addr);
        end
      end
      if (bus.d_ack) begin
        if (exp_d_gap > 0 && last_d_cyc >= 0) check_eq("d_ack_gap", cyc - last_d_cyc, exp_d_gap);
        last_d_cyc = cyc;
      end
    end
    prev_ia = bus.if_ack;
    prev_da = bus.d_ack;
  end

  task automatic do_reset();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctl"}, {bus.fl_rd, bus.if_ack, bus.d_ack, bus.if_err, bus.d_err}, 0);
    check_eq({tag, "_fl_addr"}, bus.fl_addr, 0);
    check_eq({tag, "_rdata"}, {bus.if_rdata, bus.d_rdata}, 0);
  endtask

  // Holds each request until it has collected its number of acks; next address after each ack.
  task automatic serve(input int n_i, input int n_d, input logic [AW-1:0] base_i, input logic [AW-1:0] base_d);
    int got_i = 0;
    int got_d = 0;
    int budget = 0;
    bus.if_addr = base_i;
    bus.d_addr  = base_d;
    bus.if_req  = (n_i > 0);
    bus.d_req   = (n_d > 0);
    while ((bus.if_req || bus.d_req) && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (bus.if_ack) begin
        got_i++;
        if (got_i >= n_i) bus.if_req = 1'b0;
        else bus.if_addr = base_i + AW'(4 * got_i);
      end
      if (bus.d_ack) begin
        got_d++;
        if (got_d >= n_d) bus.d_req = 1'b0;
        else bus.d_addr = base_d + AW'(4 * got_d);
      end
    end
    check_eq("serve_in_budget", budget < 2000, 1);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int b = 0;
    while (!bus.flash_busy && b < 50) begin
      @(negedge clk);
      b++;
    end
    check_eq(tag, bus.flash_busy, 1);
    @(negedge clk);
  endtask

  initial begin
    int b;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req  = 1'b0; bus.d_addr  = '0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Single fetch, minimum latency.
    busy_len = 1;
    push_exp(GNT_I, 32'h100, 32'hDEADBEEF, 1'b0, 3);
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    @(negedge clk);
    check_eq("t1_fl_rd", bus.fl_rd, 1);
    b = 0;
    while (!bus.if_ack && b < 50) begin
      @(negedge clk);
      b++;
    end
    check_eq("t1_ack_seen", bus.if_ack, 1);
    bus.if_req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t1_ack_low", bus.if_ack, 0);
    check_eq("t1_rdata_hold", bus.if_rdata, 32'hDEADBEEF);

    // Contended after reset: I, D, I, D.
    do_reset();
    push_exp(GNT_I, 32'h1000, data_fn(32'h1000), 1'b0, 3);
    push_exp(GNT_D, 32'h2000, data_fn(32'h2000), 1'b0, 3);
    push_exp(GNT_I, 32'h1004, data_fn(32'h1004), 1'b0, 3);
    push_exp(GNT_D, 32'h2004, data_fn(32'h2004), 1'b0, 3);
    serve(2, 2, 32'h1000, 32'h2000);
    repeat (2) @(negedge clk);
    check_eq("t2_sb_drained", sb.size(), 0);

    // Data-only stream with 3-cycle busy.
    busy_len = 3;
    exp_d_gap = 7;
    last_d_cyc = -1;
    for (int k = 0; k < 4; k++)
      push_exp(GNT_D, 32'h300 + 32'(4 * k), data_fn(32'h300 + 32'(4 * k)), 1'b0, 5);
    serve(0, 4, 32'h0, 32'h300);
    exp_d_gap = 0;
    repeat (2) @(negedge clk);
    check_eq("t3_sb_drained", sb.size(), 0);

    // Address change during the transfer is ignored.
    push_exp(GNT_D, 32'h20, data_fn(32'h20), 1'b0, 5);
    bus.d_addr = 32'h20;
    bus.d_req  = 1'b1;
    wait_busy("t4_busy_rose");
    bus.d_addr = 32'h40;
    @(negedge clk);
    check_eq("t4_fl_addr", bus.fl_addr, 32'h20);
    b = 0;
    while (!bus.d_ack && b < 50) begin
      @(negedge clk);
      b++;
    end
    check_eq("t4_ack_seen", bus.d_ack, 1);
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-transfer in WAIT_DONE.
    push_exp(GNT_I, 32'h500, data_fn(32'h500), 1'b0, 5);
    bus.if_addr = 32'h500;
    bus.if_req  = 1'b1;
    wait_busy("t5_busy_rose");
    rst = 1'b0;
    bus.if_req = 1'b0;
    @(negedge clk);
    check_outputs_zero("t5_rst");
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t5_no_ack", bus.if_ack | bus.d_ack, 0);
    busy_len = 1;
    push_exp(GNT_I, 32'h600, data_fn(32'h600), 1'b0, 3);
    push_exp(GNT_D, 32'h700, data_fn(32'h700), 1'b0, 3);
    serve(1, 1, 32'h600, 32'h700);
    repeat (2) @(negedge clk);
    check_eq("t5_sb_drained", sb.size(), 0);

    // Flash stuck busy.
    busy_stuck = 1;
`ifdef FLASH_ARB_TIMEOUT_EN
    push_exp(GNT_I, 32'h800, 32'h0, 1'b1, 10);
    serve(1, 0, 32'h800, 32'h0);
    repeat (2) @(negedge clk);
    check_eq("t6_sb_drained", sb.size(), 0);
`else
    push_exp(GNT_I, 32'h800, 32'h0, 1'b0, 10);
    bus.if_addr = 32'h800;
    bus.if_req  = 1'b1;
    repeat (1000) @(negedge clk);
    check_eq("t6_no_ack_stuck", sb.size(), 1);
    bus.if_req = 1'b0;
`endif
    busy_stuck = 0;
    do_reset();
    check_outputs_zero("final_rst");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
